// File: rtl/exact_4x4.sv
`default_nettype none
// ============================================================================
// exact_4x4 : exact unsigned 4x4->8 multiplier built from four 2x2 blocks,
//             with a registered product output.
// Revision   : 1.0
// ============================================================================
module exact_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] Y
);

  // 2x2 exact block; bit 3 only sets for 3*3, and it also clears bit 2 there.
  function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] y);
    logic all_ones;
    all_ones = x[1] & x[0] & y[1] & y[0];
    mul2x2   = {all_ones,
                (x[1] & y[1]) ^ all_ones,
                (x[1] & y[0]) ^ (x[0] & y[1]),
                x[0] & y[0]};
  endfunction

  logic [3:0] w_p0;
  logic [3:0] w_p1;
  logic [3:0] w_p2;
  logic [3:0] w_p3;
  logic [7:0] y_d;
  logic [7:0] y_q;

  always_comb begin
    w_p0 = mul2x2(a[1:0], b[1:0]);
    w_p1 = mul2x2(a[3:2], b[1:0]);
    w_p2 = mul2x2(a[1:0], b[3:2]);
    w_p3 = mul2x2(a[3:2], b[3:2]);
    y_d  = {4'b0000, w_p0}
         + {2'b00, w_p1, 2'b00}
         + {2'b00, w_p2, 2'b00}
         + {w_p3, 4'b0000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 8'd0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_exact_4x4.sv
`default_nettype none
// ============================================================================
// tb_exact_4x4 : scoreboard bench for exact_4x4 (directed + random operands).
// Revision     : 1.0
// ============================================================================
module tb_exact_4x4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] Y;

  typedef struct {
    int unsigned ea;
    int unsigned eb;
    bit          er;
    int unsigned exp;
  } item_t;

  item_t exp_q[$];
  int    n_tests;
  int    n_fail;
  bit    done;

  exact_4x4 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .Y   (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the product of two naturals, or zero when reset is sampled.
  task automatic apply(input bit r, input int unsigned x, input int unsigned y);
    item_t it;
    @(negedge clk);
    rst = r;
    a   = 4'(x);
    b   = 4'(y);
    it.ea  = x;
    it.eb  = y;
    it.er  = r;
    it.exp = r ? 0 : x * y;
    exp_q.push_back(it);
  endtask

  // Monitor: one result per rising edge, sampled just after the edge.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        n_tests++;
        if (32'(Y) != it.exp) begin
          n_fail++;
          $display("FAIL product a=%0d b=%0d rst=%0d: got %0d, expected %0d",
                   it.ea, it.eb, it.er, Y, it.exp);
        end
      end
    end
  end

  // Between-edge stability: Y must not move while the clock is low.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      held = Y;
      #3;
      if (!done && rst === 1'b0) begin
        n_tests++;
        if (Y !== held) begin
          n_fail++;
          $display("FAIL stable: got %0d, expected %0d", Y, held);
        end
      end
    end
  end

  initial begin
    int waits;
    n_tests = 0;
    n_fail  = 0;
    done    = 1'b0;
    rst     = 1'b1;
    a       = 4'd0;
    b       = 4'd0;

    // Reset held with full-scale operands, then release.
    apply(1, 15, 15);
    apply(1, 15, 15);
    apply(0, 15, 15);

    // Exhaustive sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        apply(0, i, j);

    // Corners.
    apply(0, 0, 15);
    apply(0, 15, 1);
    apply(0, 1, 1);
    apply(0, 3, 3);
    apply(0, 12, 12);

    // Back-to-back.
    apply(0, 7, 9);
    apply(0, 9, 7);
    apply(0, 15, 14);

    // Mid-stream reset.
    apply(0, 5, 6);
    apply(1, 8, 8);
    apply(0, 2, 13);

    // Hold.
    for (int k = 0; k < 5; k++) apply(0, 11, 13);

    // Random operands with occasional reset.
    for (int k = 0; k < 200; k++)
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 15), $urandom_range(0, 15));

    waits = 0;
    while (exp_q.size() > 0 && waits < 10) begin
      @(posedge clk);
      waits++;
    end
    #2;
    done = 1'b1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
